// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared types and constants for the cache memory-port arbiter
package cache_pkg;

    typedef enum logic [1:0] {IDLE, ADDR, DATA} arb_state_t;
    typedef enum logic {OWN_D, OWN_I} arb_owner_t;

    localparam logic [1:0] SIZE_WORD = 2'b10;

endpackage

// File: rtl/cache_mem_arbiter_if.sv
// rtl/cache_mem_arbiter_if.sv - sram-like request/response port between a cache and the memory side
interface cache_mem_arbiter_if;

    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        addr_ok;
    logic        data_ok;

    modport master (output req, wr, size, addr, wdata, input rdata, addr_ok, data_ok);
    modport slave  (input req, wr, size, addr, wdata, output rdata, addr_ok, data_ok);

endinterface

// File: rtl/arb_prio_starve.sv
// rtl/arb_prio_starve.sv - data-first pick with a saturating counter that guarantees instruction progress
module arb_prio_starve #(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic arb_en,
    input  logic i_req,
    input  logic d_req,
    output logic grant_d,
    output logic grant_i
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] starve_cnt;
    logic             starved;

    always_comb begin
        starved = (starve_cnt == LIMIT);
        grant_d = arb_en && d_req && !(i_req && starved);
        grant_i = arb_en && i_req && !grant_d;
    end

    // Every grant leaves IDLE, so each grant is counted exactly once.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (grant_d && i_req) begin
            if (!starved) starve_cnt <= starve_cnt + 1'b1;
        end else if (grant_d || grant_i) begin
            starve_cnt <= '0;
        end
    end

endmodule

// File: rtl/cache_mem_arbiter.sv
// rtl/cache_mem_arbiter.sv - shares one memory port between icache and dcache, one transaction at a time
import cache_pkg::*;

module cache_mem_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 3
) (
    input  logic               clk,
    input  logic               rst,
    cache_mem_arbiter_if.slave  i_bus,
    cache_mem_arbiter_if.slave  d_bus,
    cache_mem_arbiter_if.master mem_bus
);

    arb_state_t state;
    arb_owner_t owner;

    logic grant_d, grant_i;
    logic idle, any_req, active, sel_i, accept, finish;

    arb_prio_starve #(
        .STARVE_LIMIT (STARVE_LIMIT),
        .CNT_W        (CNT_W)
    ) u_prio (
        .clk     (clk),
        .rst     (rst),
        .arb_en  (idle),
        .i_req   (i_bus.req),
        .d_req   (d_bus.req),
        .grant_d (grant_d),
        .grant_i (grant_i)
    );

    // In IDLE the fresh pick steers the port; afterwards the registered owner does.
    always_comb begin
        idle    = (state == IDLE);
        any_req = i_bus.req || d_bus.req;
        active  = (idle && any_req) || (state == ADDR);
        sel_i   = idle ? grant_i : (owner == OWN_I);
        accept  = active && mem_bus.addr_ok;
        finish  = mem_bus.data_ok && ((state == DATA) || accept);

        mem_bus.req   = active;
        mem_bus.wr    = active && !sel_i && d_bus.wr;
        mem_bus.size  = !active ? 2'b00 : (sel_i ? SIZE_WORD : d_bus.size);
        mem_bus.addr  = !active ? 32'h0 : (sel_i ? i_bus.addr : d_bus.addr);
        mem_bus.wdata = (active && !sel_i) ? d_bus.wdata : 32'h0;

        i_bus.addr_ok = accept && sel_i;
        d_bus.addr_ok = accept && !sel_i;
        i_bus.data_ok = finish && sel_i;
        d_bus.data_ok = finish && !sel_i;
        i_bus.rdata   = mem_bus.rdata;
        d_bus.rdata   = mem_bus.rdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            owner <= OWN_D;
        end else begin
            case (state)
                IDLE: if (any_req) begin
                    owner <= grant_i ? OWN_I : OWN_D;
                    state <= mem_bus.addr_ok ? (mem_bus.data_ok ? IDLE : DATA) : ADDR;
                end
                ADDR: if (mem_bus.addr_ok) state <= mem_bus.data_ok ? IDLE : DATA;
                DATA: if (mem_bus.data_ok) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// tb/tb_cache_mem_arbiter.sv - scoreboard bench for the cache memory-port arbiter
`timescale 1ns/1ps
module tb_cache_mem_arbiter;
    import cache_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cache_mem_arbiter_if i_bus();
    cache_mem_arbiter_if d_bus();
    cache_mem_arbiter_if mem_bus();

    cache_mem_arbiter #(.STARVE_LIMIT(4), .CNT_W(3)) dut (
        .clk(clk), .rst(rst), .i_bus(i_bus), .d_bus(d_bus), .mem_bus(mem_bus)
    );

    typedef struct packed {
        logic        side;   // 1 = instruction, 0 = data
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
    } txn_t;

    txn_t        d_cmd_q[$], i_cmd_q[$], exp_q[$];
    logic        side_q[$];
    logic [31:0] rd_q[$];

    int n_chk = 0, n_fail = 0, cyc = 0;
    int n_acc[2], acc_cyc[2], done_cyc[2];
    int iph = 0, dph = 0;
    logic i_acc = 0, i_done = 0, d_acc = 0, d_done = 0;

    int ao_lat = 0, do_lat = 0, waited = 0, dcnt = 0;
    bit mm_busy = 0, mm_stale = 0;
    logic [31:0] rd_next = 32'h0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic txn_t mk(input logic s, input logic w, input logic [1:0] sz,
                                input logic [31:0] a, input logic [31:0] wd);
        txn_t t;
        t.side = s; t.wr = w; t.size = sz; t.addr = a; t.wdata = wd;
        return t;
    endfunction

    // Instruction requester; wr/size/wdata carry junk the arbiter must override.
    initial begin : i_drv
        txn_t c;
        i_bus.req = 0; i_bus.addr = 0; i_bus.wr = 1; i_bus.size = 2'b01; i_bus.wdata = 32'hFFFF_FFFF;
        forever begin
            @(posedge clk); #1;
            if (rst) begin iph = 0; i_bus.req = 0; end
            else begin
                if (iph == 1 && i_acc) begin i_bus.req = 0; iph = i_done ? 0 : 2; end
                else if (iph == 2 && i_done) iph = 0;
                if (iph == 0 && i_cmd_q.size() > 0) begin
                    c = i_cmd_q.pop_front(); i_bus.addr = c.addr; i_bus.req = 1; iph = 1;
                end
            end
        end
    end

    initial begin : d_drv
        txn_t c;
        d_bus.req = 0; d_bus.addr = 0; d_bus.wr = 0; d_bus.size = 0; d_bus.wdata = 0;
        forever begin
            @(posedge clk); #1;
            if (rst) begin dph = 0; d_bus.req = 0; end
            else begin
                if (dph == 1 && d_acc) begin d_bus.req = 0; dph = d_done ? 0 : 2; end
                else if (dph == 2 && d_done) dph = 0;
                if (dph == 0 && d_cmd_q.size() > 0) begin
                    c = d_cmd_q.pop_front();
                    d_bus.addr = c.addr; d_bus.wr = c.wr; d_bus.size = c.size; d_bus.wdata = c.wdata;
                    d_bus.req = 1; dph = 1;
                end
            end
        end
    end

    task mm_fire;
        mem_bus.data_ok = 1; mem_bus.rdata = rd_next;
        rd_q.push_back(rd_next); rd_next = rd_next + 32'h0101_0101;
    endtask

    // Memory model with programmable address-accept and data latencies.
    initial begin : mem_model
        mem_bus.addr_ok = 0; mem_bus.data_ok = 0; mem_bus.rdata = 0;
        forever begin
            @(posedge clk); #2;
            mem_bus.addr_ok = 0; mem_bus.data_ok = 0;
            if (rst) begin mm_busy = 0; waited = 0; end
            else if (mm_stale) mem_bus.data_ok = 1;
            else if (mm_busy) begin
                if (dcnt == 0) begin mm_fire(); mm_busy = 0; end
                else dcnt--;
            end else if (mem_bus.req) begin
                if (waited >= ao_lat) begin
                    mem_bus.addr_ok = 1; waited = 0;
                    if (do_lat == 0) mm_fire();
                    else begin mm_busy = 1; dcnt = do_lat - 1; end
                end else waited++;
            end
        end
    end

    initial begin : mon
        txn_t e;
        logic s;
        logic [31:0] r;
        forever begin
            @(negedge clk);
            i_acc = i_bus.addr_ok; i_done = i_bus.data_ok;
            d_acc = d_bus.addr_ok; d_done = d_bus.data_ok;
            if (!rst) begin
                if (mem_bus.req && mem_bus.addr_ok) begin
                    if (exp_q.size() == 0) chk("unexpected_grant", {i_acc, d_acc}, 2'b00);
                    else begin
                        e = exp_q.pop_front();
                        chk("grant_side", {i_acc, d_acc}, e.side ? 2'b10 : 2'b01);
                        chk("mem_wr", mem_bus.wr, e.wr);
                        chk("mem_size", mem_bus.size, e.size);
                        chk("mem_addr", mem_bus.addr, e.addr);
                        chk("mem_wdata", mem_bus.wdata, e.wdata);
                        side_q.push_back(e.side);
                        n_acc[e.side]++; acc_cyc[e.side] = cyc;
                    end
                end else if (i_acc || d_acc) chk("spurious_addr_ok", {i_acc, d_acc}, 2'b00);
                if (mem_bus.data_ok && rd_q.size() > 0 && side_q.size() > 0) begin
                    r = rd_q.pop_front(); s = side_q.pop_front();
                    chk("done_side", {i_done, d_done}, s ? 2'b10 : 2'b01);
                    chk("rdata", s ? i_bus.rdata : d_bus.rdata, r);
                    done_cyc[s] = cyc;
                end else if (i_done || d_done) chk("spurious_data_ok", {i_done, d_done}, 2'b00);
            end
        end
    end

    task automatic wait_quiet(input string tag);
        int t = 0;
        while ((d_cmd_q.size() > 0 || i_cmd_q.size() > 0 || dph != 0 || iph != 0 ||
                exp_q.size() > 0 || side_q.size() > 0) && t < 300) begin
            @(negedge clk); #1; t++;
        end
        chk({tag, "_complete"}, t < 300, 1'b1);
        @(negedge clk); #1;
    endtask

    task automatic wait_acc(input int s, input int base);
        int t = 0;
        while (n_acc[s] == base && t < 300) begin @(negedge clk); #1; t++; end
        chk("grant_wait", t < 300, 1'b1);
    endtask

    initial begin : main
        int base;
        txn_t t;
        repeat (3) @(negedge clk);
        #1 rst = 0;
        @(negedge clk); #1;
        chk("rst_mem_req", mem_bus.req, 1'b0);
        chk("rst_mem_fields", {mem_bus.wr, mem_bus.size, mem_bus.addr, mem_bus.wdata}, 67'h0);
        chk("rst_oks", {i_bus.addr_ok, i_bus.data_ok, d_bus.addr_ok, d_bus.data_ok}, 4'h0);
        chk("rst_state", dut.state, IDLE);
        chk("rst_owner", dut.owner, OWN_D);
        chk("rst_starve", dut.u_prio.starve_cnt, 3'd0);

        // single d read
        ao_lat = 0; do_lat = 3; rd_next = 32'hDEAD_BEEF;
        t = mk(0, 0, 2'b10, 32'h1000, 0); exp_q.push_back(t); d_cmd_q.push_back(t);
        wait_quiet("single_d");
        chk("single_d_latency", done_cyc[0] - acc_cyc[0], 3);
        chk("single_d_no_i", n_acc[1], 0);

        // simultaneous: d write first, i one cycle after d completes
        do_lat = 2; rd_next = 32'h0000_0100;
        t = mk(0, 1, 2'b10, 32'h2004, 32'h1234_5678); exp_q.push_back(t); d_cmd_q.push_back(t);
        t = mk(1, 0, SIZE_WORD, 32'h3000, 0); exp_q.push_back(t); i_cmd_q.push_back(t);
        wait_quiet("simul");
        chk("simul_i_gap", acc_cyc[1] - done_cyc[0], 1);

        // starvation: four d grants, then i
        do_lat = 1;
        for (int k = 0; k < 5; k++) begin
            t = mk(0, 0, 2'b10, 32'h8000 + 32'(k * 4), 0); d_cmd_q.push_back(t);
            if (k < 4) exp_q.push_back(t);
        end
        t = mk(1, 0, SIZE_WORD, 32'h3100, 0); i_cmd_q.push_back(t); exp_q.push_back(t);
        exp_q.push_back(mk(0, 0, 2'b10, 32'h8010, 0));
        base = n_acc[1];
        wait_acc(1, base);
        chk("starve_at_i_grant", dut.u_prio.starve_cnt, 3'd4);
        @(negedge clk); #1;
        chk("starve_after_i", dut.u_prio.starve_cnt, 3'd0);
        wait_quiet("starve");

        // delayed addr_ok: i holds the port, late d does not preempt
        ao_lat = 3; do_lat = 1;
        exp_q.push_back(mk(1, 0, SIZE_WORD, 32'h4000, 0));
        exp_q.push_back(mk(0, 0, 2'b01, 32'h5000, 0));
        i_cmd_q.push_back(mk(1, 0, SIZE_WORD, 32'h4000, 0));
        begin
            int w = 0;
            while (!mem_bus.req && w < 20) begin @(negedge clk); #1; w++; end
            chk("delay_req_seen", mem_bus.req, 1'b1);
        end
        for (int k = 0; k < 3; k++) begin
            chk("delay_mem_req", mem_bus.req, 1'b1);
            chk("delay_mem_addr", mem_bus.addr, 32'h4000);
            if (k == 0) d_cmd_q.push_back(mk(0, 0, 2'b01, 32'h5000, 0));
            @(negedge clk); #1;
        end
        wait_quiet("delay");
        ao_lat = 0;

        // same-cycle accept and complete
        do_lat = 0; rd_next = 32'hCAFE_F00D;
        t = mk(0, 0, 2'b10, 32'h6000, 0); exp_q.push_back(t);
        base = n_acc[0];
        d_cmd_q.push_back(t);
        wait_acc(0, base);
        chk("same_cycle_done", done_cyc[0] - acc_cyc[0], 0);
        @(negedge clk); #1;
        chk("same_cycle_idle", dut.state, IDLE);
        wait_quiet("same_cycle");

        // reset while waiting for data
        do_lat = 20;
        t = mk(0, 0, 2'b10, 32'h7000, 0); exp_q.push_back(t);
        base = n_acc[0];
        d_cmd_q.push_back(t);
        wait_acc(0, base);
        @(negedge clk); #1;
        chk("mid_state_data", dut.state, DATA);
        rst = 1;
        @(negedge clk); #1;
        chk("rst_mid_state", dut.state, IDLE);
        chk("rst_mid_oks", {i_bus.addr_ok, i_bus.data_ok, d_bus.addr_ok, d_bus.data_ok}, 4'h0);
        side_q.delete();
        rst = 0; mm_stale = 1;
        @(negedge clk); #1;
        mm_stale = 0;
        chk("stale_data_ok_ignored", {i_bus.data_ok, d_bus.data_ok}, 2'b00);
        @(negedge clk); #1;
        chk("stale_state_idle", dut.state, IDLE);
        chk("stale_mem_req", mem_bus.req, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
